inst_fetch: RTL and testbench

Instruction fetch unit feeding the core's `INST` input. It owns the fetch PC and issues word reads to instruction memory over a request/grant/response handshake. Returned words are buffered in a small in-order FIFO and presented to the core with a valid/ready handshake. The core redirects the fetch stream (branch, jump, trap) with a one-cycle `REDIRECT` pulse, which flushes buffered and in-flight words.

---
 rtl/inst_fetch_pkg.sv | 15 +
 rtl/inst_fetch_fifo.sv | 76 +++++++
 rtl/inst_fetch.sv | 147 ++++++++++++++
 tb/tb_inst_fetch.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared fetch types: instruction word, fetch FSM state, default FIFO depth.
// The FETCH_MISALIGN_TRAP_EN macro enables the HALT state and the FAULT port.
package typePack;

    typedef logic [31:0] instruction_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } fetch_state_t;

    localparam int FETCH_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/inst_fetch_fifo.sv
// In-order {pc, instruction} FIFO with flush.
// Shift organisation keeps the head in entry 0, so head outputs come straight from flops.
module fetch_fifo
    import typePack::*;
#(
    parameter int DEPTH = FETCH_DEPTH_DEFAULT,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [31:0]  push_pc,
    input  instruction_t push_inst,
    output logic [31:0]  head_pc,
    output instruction_t head_inst,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    logic [31:0]   pc_q  [DEPTH];
    logic [31:0]   pc_n  [DEPTH];
    instruction_t  ins_q [DEPTH];
    instruction_t  ins_n [DEPTH];
    logic [CW-1:0] cnt_n;

    always_comb begin
        pc_n  = pc_q;
        ins_n = ins_q;
        cnt_n = count;
        if (flush) begin
            cnt_n = '0;
        end else begin
            if (pop && !empty) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    pc_n[i]  = pc_q[i+1];
                    ins_n[i] = ins_q[i+1];
                end
                cnt_n = count - CW'(1);
            end
            if (push && cnt_n != CW'(DEPTH)) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == cnt_n) begin
                        pc_n[i]  = push_pc;
                        ins_n[i] = push_inst;
                    end
                end
                cnt_n = cnt_n + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]  <= '0;
                ins_q[i] <= '0;
            end
        end else begin
            count <= cnt_n;
            empty <= (cnt_n == '0);
            full  <= (cnt_n == CW'(DEPTH));
            pc_q  <= pc_n;
            ins_q <= ins_n;
        end
    end

    assign head_pc   = pc_q[0];
    assign head_inst = ins_q[0];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: fetch PC, request/grant/response memory port, redirect flush.
// FETCH_MISALIGN_TRAP_EN adds the FAULT port and halts on misaligned redirects.
module inst_fetch
    import typePack::*;
#(
    parameter int          DEPTH    = FETCH_DEPTH_DEFAULT,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         CLOCK,
    input  logic         RESET,
    input  logic         REDIRECT,
    input  logic [31:0]  REDIRECT_PC,
    output logic         MEM_REQ,
    output logic [31:0]  MEM_ADDR,
    input  logic         MEM_GNT,
    input  logic         MEM_RVALID,
    input  logic [31:0]  MEM_RDATA,
    output instruction_t INST,
    output logic [31:0]  INST_PC,
    output logic         INST_VALID,
    input  logic         INST_READY
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic         FAULT
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    fetch_state_t  state;
    logic          req;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] kill;
    logic [31:0]   pcq [DEPTH];
    logic [AW-1:0] pcq_wr;
    logic [AW-1:0] pcq_rd;

    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          gnt;
    logic          rsp;
    logic          keep;
    logic          pop;
    logic          misalign;
    logic          run_nx;
    logic          req_nx;
    logic [31:0]   target;
    logic [31:0]   pc_nx;
    logic [CW-1:0] out_nx;
    logic [CW-1:0] kill_nx;
    logic [CW-1:0] cnt_nx;
    logic [CW:0]   inflight;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault;
    assign target   = REDIRECT_PC;
    assign misalign = (REDIRECT_PC[1:0] != 2'b00);
    assign FAULT    = fault;
`else
    assign target   = REDIRECT_PC & 32'hFFFF_FFFC;
    assign misalign = 1'b0;
`endif

    assign gnt  = req & MEM_GNT;
    assign rsp  = MEM_RVALID && (outstanding != '0);
    assign keep = rsp && (kill == '0) && !REDIRECT && !fifo_full;
    assign pop  = !fifo_empty && INST_READY && !REDIRECT;

    // Kill count is taken after this cycle's grant and response settle.
    assign out_nx = outstanding + CW'(gnt) - CW'(rsp);

    always_comb begin
        kill_nx = kill;
        if (REDIRECT)
            kill_nx = out_nx;
        else if (rsp && kill != '0)
            kill_nx = kill - CW'(1);
    end

    assign cnt_nx   = REDIRECT ? '0 : fifo_count + CW'(keep) - CW'(pop);
    assign pc_nx    = REDIRECT ? target
                    : gnt      ? fetch_pc + 32'd4
                    :            fetch_pc;
    assign run_nx   = REDIRECT ? !misalign : (state != HALT);
    assign inflight = {1'b0, cnt_nx} + {1'b0, out_nx};
    assign req_nx   = run_nx && (inflight < (CW+1)'(DEPTH));

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state       <= IDLE;
            req         <= 1'b0;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            kill        <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE:      state <= RUN;
                RUN, HALT: state <= state;
                default:   state <= IDLE;
            endcase
            if (REDIRECT)
                state <= misalign ? HALT : RUN;
            req         <= req_nx;
            fetch_pc    <= pc_nx;
            outstanding <= out_nx;
            kill        <= kill_nx;
            if (gnt) begin
                pcq[pcq_wr] <= fetch_pc;
                pcq_wr      <= pcq_wr + AW'(1);
            end
            if (rsp)
                pcq_rd <= pcq_rd + AW'(1);
`ifdef FETCH_MISALIGN_TRAP_EN
            if (REDIRECT)
                fault <= misalign;
`endif
        end
    end

    assign MEM_REQ    = req;
    assign MEM_ADDR   = fetch_pc;
    assign INST_VALID = !fifo_empty;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (CLOCK),
        .rst       (RESET),
        .flush     (REDIRECT),
        .push      (keep),
        .pop       (pop),
        .push_pc   (pcq[pcq_rd]),
        .push_inst (MEM_RDATA),
        .head_pc   (INST_PC),
        .head_inst (INST),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: vector table plus redirect/stall sequences.
// Memory model grants when enabled and answers addr ^ 32'hFFFF_FFFF after a set latency.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic        REDIRECT = 1'b0;
    logic [31:0] REDIRECT_PC = '0;
    logic        MEM_REQ;
    logic [31:0] MEM_ADDR;
    logic        MEM_GNT = 1'b1;
    logic        MEM_RVALID = 1'b0;
    logic [31:0] MEM_RDATA = '0;
    logic [31:0] INST;
    logic [31:0] INST_PC;
    logic        INST_VALID;
    logic        INST_READY = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fault;
`endif

    inst_fetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .CLOCK       (clk),
        .RESET       (RESET),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .MEM_REQ     (MEM_REQ),
        .MEM_ADDR    (MEM_ADDR),
        .MEM_GNT     (MEM_GNT),
        .MEM_RVALID  (MEM_RVALID),
        .MEM_RDATA   (MEM_RDATA),
        .INST        (INST),
        .INST_PC     (INST_PC),
        .INST_VALID  (INST_VALID),
        .INST_READY  (INST_READY)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .FAULT       (fault)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    vec_t  vt[$];
    pend_t pend[$];
    int    lat = 1;
    logic  gnt_en = 1'b1;
    int    cyc = 0;
    int    n_vec = 0;
    int    n_bad = 0;

    task automatic add(input logic rst, input logic rdy, input logic req,
                       input logic [31:0] addr, input logic vld,
                       input logic [31:0] pc);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.req = req;
        v.addr = addr; v.vld = vld; v.pc = pc;
        vt.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One clock: edge, then update the memory model from what it saw at the edge.
    task automatic tick();
        logic        g;
        logic        r;
        logic [31:0] a;
        pend_t       p;
        g = MEM_REQ & MEM_GNT;
        r = MEM_RVALID;
        a = MEM_ADDR;
        @(posedge clk);
        #1;
        cyc++;
        if (RESET) begin
            pend.delete();
        end else begin
            if (r && pend.size() > 0) void'(pend.pop_front());
            if (g) begin
                p.addr = a;
                p.due  = cyc + lat - 1;
                pend.push_back(p);
            end
        end
        MEM_RVALID = 1'b0;
        MEM_RDATA  = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            MEM_RVALID = 1'b1;
            MEM_RDATA  = pend[0].addr ^ 32'hFFFF_FFFF;
        end
        MEM_GNT = gnt_en;
    endtask

    task automatic set_gnt(input logic v);
        gnt_en  = v;
        MEM_GNT = v;
    endtask

    task automatic do_reset();
        RESET    = 1'b1;
        REDIRECT = 1'b0;
        tick();
        RESET    = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        REDIRECT    = 1'b1;
        REDIRECT_PC = pc;
        tick();
        REDIRECT    = 1'b0;
    endtask

    task automatic wait_valid(input logic [31:0] exp_pc, input string nm);
        bit seen;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (INST_VALID) begin
                seen = 1;
                chk({nm, ".pc"}, INST_PC, exp_pc);
                chk({nm, ".inst"}, INST, exp_pc ^ 32'hFFFF_FFFF);
            end
        end
        if (!seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: got no INST_VALID in 40 cycles want pc %h",
                     nm, exp_pc);
        end
    endtask

    initial begin
        // Reset release, always ready: requests 0,4,8..., INST_PC 0 on 3rd edge.
        add(1, 1, 0, 32'h00, 0, 32'h00);
        add(0, 1, 1, 32'h00, 0, 32'h00);
        add(0, 1, 1, 32'h04, 0, 32'h00);
        add(0, 1, 1, 32'h08, 1, 32'h00);
        add(0, 1, 1, 32'h0C, 1, 32'h04);
        add(0, 1, 1, 32'h10, 1, 32'h08);
        add(0, 1, 1, 32'h14, 1, 32'h0C);
        // Core stalled: four grants fill the FIFO, then drain in order.
        add(1, 0, 0, 32'h00, 0, 32'h00);
        add(0, 0, 1, 32'h00, 0, 32'h00);
        add(0, 0, 1, 32'h04, 0, 32'h00);
        add(0, 0, 1, 32'h08, 1, 32'h00);
        add(0, 0, 1, 32'h0C, 1, 32'h00);
        add(0, 0, 0, 32'h10, 1, 32'h00);
        add(0, 0, 0, 32'h10, 1, 32'h00);
        add(0, 0, 0, 32'h10, 1, 32'h00);
        add(0, 1, 1, 32'h10, 1, 32'h04);
        add(0, 1, 1, 32'h14, 1, 32'h08);
        add(0, 1, 1, 32'h18, 1, 32'h0C);
        add(0, 1, 1, 32'h1C, 1, 32'h10);
        add(0, 1, 1, 32'h20, 1, 32'h14);

        foreach (vt[i]) begin
            RESET      = vt[i].rst;
            INST_READY = vt[i].rdy;
            tick();
            chk($sformatf("v%0d.req", i), 32'(MEM_REQ), 32'(vt[i].req));
            chk($sformatf("v%0d.addr", i), MEM_ADDR, vt[i].addr);
            chk($sformatf("v%0d.valid", i), 32'(INST_VALID), 32'(vt[i].vld));
            if (vt[i].vld || vt[i].rst) begin
                chk($sformatf("v%0d.pc", i), INST_PC, vt[i].pc);
                chk($sformatf("v%0d.inst", i), INST,
                    vt[i].rst ? 32'h0 : vt[i].pc ^ 32'hFFFF_FFFF);
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            if (vt[i].rst) chk($sformatf("v%0d.fault", i), 32'(fault), 32'h0);
`endif
        end
        RESET = 1'b0;

        // Latency 3, two requests in flight (third granted in the redirect cycle).
        lat = 3;
        INST_READY = 1'b1;
        do_reset();
        repeat (3) tick();
        chk("lat3.addr_pre", MEM_ADDR, 32'h08);
        redirect(32'h100);
        chk("lat3.valid_r1", 32'(INST_VALID), 32'h0);
        chk("lat3.req_r1", 32'(MEM_REQ), 32'h1);
        chk("lat3.addr_r1", MEM_ADDR, 32'h100);
        wait_valid(32'h100, "lat3.first");
        lat = 1;

        // Redirect coincides with a pop and a response.
        do_reset();
        repeat (3) tick();
        chk("coinc.pc_pre", INST_PC, 32'h0);
        chk("coinc.valid_pre", 32'(INST_VALID), 32'h1);
        redirect(32'h100);
        chk("coinc.valid_r1", 32'(INST_VALID), 32'h0);
        chk("coinc.addr_r1", MEM_ADDR, 32'h100);
        chk("coinc.req_r1", 32'(MEM_REQ), 32'h1);
        wait_valid(32'h100, "coinc.first");

        // Grant withheld five cycles: request held, address frozen.
        set_gnt(1'b0);
        do_reset();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d.req", i), 32'(MEM_REQ), 32'h1);
            chk($sformatf("stall%0d.addr", i), MEM_ADDR, 32'h0);
            tick();
        end
        set_gnt(1'b1);
        tick();
        chk("stall.addr_after", MEM_ADDR, 32'h4);

        // Misaligned redirect.
        do_reset();
        repeat (3) tick();
`ifdef FETCH_MISALIGN_TRAP_EN
        redirect(32'h102);
        chk("mis.fault", 32'(fault), 32'h1);
        chk("mis.req", 32'(MEM_REQ), 32'h0);
        repeat (4) tick();
        chk("mis.req_hold", 32'(MEM_REQ), 32'h0);
        chk("mis.valid_hold", 32'(INST_VALID), 32'h0);
        chk("mis.fault_hold", 32'(fault), 32'h1);
        redirect(32'h200);
        chk("mis.fault_clr", 32'(fault), 32'h0);
        chk("mis.req_new", 32'(MEM_REQ), 32'h1);
        chk("mis.addr_new", MEM_ADDR, 32'h200);
        wait_valid(32'h200, "mis.first");
`else
        redirect(32'h102);
        chk("mis.req", 32'(MEM_REQ), 32'h1);
        chk("mis.addr", MEM_ADDR, 32'h100);
        wait_valid(32'h100, "mis.first");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
